// File: rtl/vga_timing_gen_if.sv
// Pixel-side bundle of the VGA timing generator: pixel enable in, sync/DE/coords/strobes out.
// The generator takes the master view; renderers and the bench take the slave view.
interface vga_timing_gen_if #(parameter int CW = 11);
  logic          PIX_EN;
  logic          Hsync_sig;
  logic          Vsync_sig;
  logic          De_sig;
  logic [CW-1:0] X_add;
  logic [CW-1:0] Y_add;
  logic          Win_sig;
  logic [CW-1:0] Win_X;
  logic [CW-1:0] Win_Y;
  logic          Line_start;
  logic          Frame_start;

  modport master (
    input  PIX_EN,
    output Hsync_sig, Vsync_sig, De_sig, X_add, Y_add,
           Win_sig, Win_X, Win_Y, Line_start, Frame_start
  );

  modport slave (
    output PIX_EN,
    input  Hsync_sig, Vsync_sig, De_sig, X_add, Y_add,
           Win_sig, Win_X, Win_Y, Line_start, Frame_start
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: h/v counters plus registered sync, DE, pixel
// coordinates, sub-window coordinates and line/frame strobes, advancing on PIX_EN.
module vga_timing_gen #(
  parameter int CW     = 11,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int H_ACT  = 640,
  parameter int H_FP   = 16,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33,
  parameter int V_ACT  = 480,
  parameter int V_FP   = 10,
  parameter bit H_POL  = 1'b0,
  parameter bit V_POL  = 1'b0,
  parameter int WIN_X0 = 0,
  parameter int WIN_Y0 = 0,
  parameter int WIN_W  = 640,
  parameter int WIN_H  = 480
) (
  input  logic               CLK_40M,
  input  logic               RSTn,
  vga_timing_gen_if.master   vga
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACT + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACT + V_FP;

  localparam logic [CW-1:0] H_SYNC_C = CW'(H_SYNC);
  localparam logic [CW-1:0] V_SYNC_C = CW'(V_SYNC);
  localparam logic [CW-1:0] HA0_C    = CW'(H_SYNC + H_BP);
  localparam logic [CW-1:0] VA0_C    = CW'(V_SYNC + V_BP);
  localparam logic [CW-1:0] H_ACT_C  = CW'(H_ACT);
  localparam logic [CW-1:0] V_ACT_C  = CW'(V_ACT);
  localparam logic [CW-1:0] H_LAST_C = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST_C = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] WX0_C    = CW'(WIN_X0);
  localparam logic [CW-1:0] WY0_C    = CW'(WIN_Y0);
  localparam logic [CW-1:0] WIN_W_C  = CW'(WIN_W);
  localparam logic [CW-1:0] WIN_H_C  = CW'(WIN_H);

  if (H_TOTAL >= (1 << CW) || V_TOTAL >= (1 << CW)) begin : g_bad_cw
    $error("vga_timing_gen: CW too narrow for H_TOTAL/V_TOTAL");
  end
  if (WIN_X0 + WIN_W > H_ACT || WIN_Y0 + WIN_H > V_ACT) begin : g_bad_win
    $error("vga_timing_gen: window exceeds active area");
  end

  logic [CW-1:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic          hsync_q, hsync_d, vsync_q, vsync_d;
  logic          de_q, de_d, win_q, win_d;
  logic [CW-1:0] x_q, x_d, y_q, y_d, wx_q, wx_d, wy_q, wy_d;
  logic          line_start_q, line_start_d, frame_start_q, frame_start_d;

  logic [CW-1:0] x_rel, y_rel, wx_rel, wy_rel;
  logic          de_s, win_s;

  // Relative coordinates rely on unsigned wrap: a position left of / above an edge
  // becomes a huge value, so one "< width" compare tests both bounds.
  always_comb begin
    x_rel  = h_cnt_q - HA0_C;
    y_rel  = v_cnt_q - VA0_C;
    wx_rel = x_rel - WX0_C;
    wy_rel = y_rel - WY0_C;
    de_s   = (x_rel < H_ACT_C) && (y_rel < V_ACT_C);
    win_s  = de_s && (wx_rel < WIN_W_C) && (wy_rel < WIN_H_C);
  end

  // Counter next-state: h wraps at end of line, v steps only on h wrap.
  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (vga.PIX_EN) begin
      if (h_cnt_q == H_LAST_C) begin
        h_cnt_d = '0;
        if (v_cnt_q == V_LAST_C) begin
          v_cnt_d = '0;
        end else begin
          v_cnt_d = v_cnt_q + CW'(1);
        end
      end else begin
        h_cnt_d = h_cnt_q + CW'(1);
      end
    end else begin
      h_cnt_d = h_cnt_q;
      v_cnt_d = v_cnt_q;
    end
  end

  // Output next-state from the pre-increment counters; levels hold and strobes drop when idle.
  always_comb begin
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    de_d          = de_q;
    x_d           = x_q;
    y_d           = y_q;
    win_d         = win_q;
    wx_d          = wx_q;
    wy_d          = wy_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    if (vga.PIX_EN) begin
      hsync_d       = (h_cnt_q < H_SYNC_C) ? H_POL : ~H_POL;
      vsync_d       = (v_cnt_q < V_SYNC_C) ? V_POL : ~V_POL;
      de_d          = de_s;
      x_d           = de_s ? x_rel : '0;
      y_d           = de_s ? y_rel : '0;
      win_d         = win_s;
      wx_d          = win_s ? wx_rel : '0;
      wy_d          = win_s ? wy_rel : '0;
      line_start_d  = (h_cnt_q == '0);
      frame_start_d = (h_cnt_q == '0) && (v_cnt_q == '0);
    end else begin
      line_start_d  = 1'b0;
      frame_start_d = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge CLK_40M or negedge RSTn) begin
    if (!RSTn) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      hsync_q       <= ~H_POL;
      vsync_q       <= ~V_POL;
      de_q          <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      win_q         <= 1'b0;
      wx_q          <= '0;
      wy_q          <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      de_q          <= de_d;
      x_q           <= x_d;
      y_q           <= y_d;
      win_q         <= win_d;
      wx_q          <= wx_d;
      wy_q          <= wy_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign vga.Hsync_sig   = hsync_q;
  assign vga.Vsync_sig   = vsync_q;
  assign vga.De_sig      = de_q;
  assign vga.X_add       = x_q;
  assign vga.Y_add       = y_q;
  assign vga.Win_sig     = win_q;
  assign vga.Win_X       = wx_q;
  assign vga.Win_Y       = wy_q;
  assign vga.Line_start  = line_start_q;
  assign vga.Frame_start = frame_start_q;

endmodule
